utf8_decode_seq: RTL
====================

UTF8_DECODE_SEQ -- requirements
Module: utf8_decode_seq

Interface
REQ-001 SHALL have these ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input byte valid
- s_data  in  8  input UTF-8 byte
- s_last  in  1  final byte of stream, qualified by s_valid
- s_ready  out  1  one-cycle pulse; byte committed
- m_valid  out  1  decoded result valid
- m_data  out  32  code point, or raw converter value on error
- m_flags  out  5  {trunc, retry, invalid, overlong, nonuni}
- m_ready  in  1  result consumed
- core_din  out  8  byte to converter
- core_bin, core_cout, core_rst_in, core_rst_out  out  1 each  converter strobes, active-low, idle high
- core_dout  in  8  converter read data
- core_ready, core_retry, core_invalid, core_overlong, core_nonuni  in  1 each  converter status

REQ-002 SHALL tie the converter's cbe high externally, so reads return the most-significant byte first.

Function
REQ-003 Every strobe SHALL be registered, low for exactly one clk, then high for at least one clk before core_* inputs are sampled or another strobe fires.
REQ-004 FSM states SHALL be CLR, FEED, CHECK, READ, OUT.
REQ-005 CLR SHALL pulse core_rst_in, then go to FEED.
REQ-006 FEED SHALL wait for s_valid, drive core_din=s_data, pulse core_bin, then go to CHECK; s_data SHALL be held in a byte register for re-feed.
REQ-007 CHECK, core_retry=1: SHALL NOT assert s_ready; SHALL go to READ; after OUT, SHALL pass through CLR and re-feed the held byte without waiting on s_valid.
REQ-008 CHECK, core_retry=0: SHALL pulse s_ready for one cycle.
REQ-009 CHECK, after REQ-008, core_ready=1: SHALL go to READ.
REQ-010 CHECK, after REQ-008, core_ready=0 and s_last=0: SHALL return to FEED.
REQ-011 READ SHALL issue four core_cout pulses and shift core_dout into m_data MSB-first (counter 0..3), then go to OUT.
REQ-012 On entry to OUT, m_flags SHALL capture core_retry, invalid, overlong, nonuni, plus the internal trunc bit.
REQ-013 OUT: m_valid=1; m_data/m_flags SHALL be stable until m_valid&m_ready, then go to CLR.
REQ-014 s_ready SHALL be 0 while m_valid=1 (no input overlap).
REQ-015 Latency: a byte completing a character SHALL yield m_valid no earlier than 12 and no later than 14 clk after its s_valid sampling; the limit SHALL be met.
REQ-016 s_last with core_ready=1 SHALL behave as a normal completion.
REQ-017 s_last with core_ready=0: see REQ-025.
REQ-018 Byte counting SHALL saturate; a 7th continuation byte SHALL be handled by the converter's retry path, never by counter wrap.

Reset
REQ-019 While rst=1: s_ready=0, m_valid=0, m_data=0, m_flags=0, core_din=0; core_bin, core_cout, core_rst_out=1; core_rst_in=0.
REQ-020 After rst deasserts, the FSM SHALL enter CLR.
REQ-021 rst mid-operation SHALL abandon the held byte and any pending result; no s_ready pulse SHALL follow.
REQ-022 core_rst_out SHALL remain high permanently; it is reserved.

Configuration
REQ-023 Macro UTF8_SEQ_TRUNC_FLUSH_EN SHALL control truncated-sequence flushing.
REQ-024 Without UTF8_SEQ_TRUNC_FLUSH_EN, trunc SHALL be constant 0.
REQ-025 With UTF8_SEQ_TRUNC_FLUSH_EN, CHECK with s_last=1 and core_ready=0 SHALL go to READ with trunc=1. Without it, s_last SHALL be ignored and the partial sequence SHALL stay pending.

Structure
REQ-026 Package utf8_pkg SHALL hold the FSM state enum, flag bit indices, strobe idle constant, and read count 4.
REQ-027 Sub-module utf8_strobe_gen SHALL produce one strobe pulse plus its settle cycle; instantiate it per strobe.
REQ-028 The converter core SHALL be instantiated outside this block.

Verification
REQ-029 E2 82 AC -> m_data=0x000020AC; flags=0; three s_ready pulses.
REQ-030 C0 80 -> m_data=0xFFFFF000; overlong=1.
REQ-031 C3 41 -> 0xFFFFFFC3 with retry=1; then 0x00000041 with flags=0; two s_ready pulses total.
REQ-032 F4 90 80 80 -> m_data=0x00110000; nonuni=1.
REQ-033 m_ready held low 20 cycles on a result -> m_data stable; s_ready=0 throughout.
REQ-034 With UTF8_SEQ_TRUNC_FLUSH_EN: E2, then 82 with s_last -> m_data=0xFFFFF882, trunc=1. Without it: no m_valid.

Source files
------------

// File: rtl/utf8_pkg.sv
// utf8_pkg: shared types and constants for the UTF-8 decode sequencer
package utf8_pkg;
    typedef enum logic [2:0] {CLR, FEED, CHECK, READ, OUT} state_t;
    localparam int FLAG_NONUNI   = 0;
    localparam int FLAG_OVERLONG = 1;
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_RETRY    = 3;
    localparam int FLAG_TRUNC    = 4;
    localparam logic STROBE_IDLE = 1'b1;
    localparam int READ_COUNT    = 4;
endpackage

// File: rtl/utf8_strobe_gen.sv
// utf8_strobe_gen: one registered active-low strobe pulse followed by one settle cycle
// Ports: fire (request, honoured when idle or done), strobe_n (to converter),
//        idle (no pulse in flight), done (settle cycle; converter status is valid now)
// RST_VAL is the strobe level held while rst=1.
module utf8_strobe_gen
    import utf8_pkg::*;
#(
    parameter logic RST_VAL = STROBE_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic strobe_n,
    output logic idle,
    output logic done
);
    logic [1:0] phase_q, phase_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        phase_d  = fire ? 2'd1 : (phase_q == 2'd1 ? 2'd2 : 2'd0);
        strobe_d = fire ? ~STROBE_IDLE : STROBE_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 2'd0;
            strobe_q <= RST_VAL;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_n = strobe_q;
    assign idle     = phase_q == 2'd0;
    assign done     = phase_q == 2'd2;
endmodule

// File: rtl/utf8_decode_seq.sv
// utf8_decode_seq: feeds UTF-8 bytes to an external converter core and returns its result
// Build option: UTF8_SEQ_TRUNC_FLUSH_EN -- s_last on an incomplete sequence flushes it with trunc=1
// Ports: s_valid/s_data/s_last in, s_ready pulses once per committed byte;
//        m_valid/m_data/m_flags out ({trunc, retry, invalid, overlong, nonuni}), m_ready in;
//        core_* : converter data/strobes (active-low) and status; core_rst_out is reserved (always high)
module utf8_decode_seq
    import utf8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic [4:0]  m_flags,
    input  logic        m_ready,
    output logic [7:0]  core_din,
    output logic        core_bin,
    output logic        core_cout,
    output logic        core_rst_in,
    output logic        core_rst_out,
    input  logic [7:0]  core_dout,
    input  logic        core_ready,
    input  logic        core_retry,
    input  logic        core_invalid,
    input  logic        core_overlong,
    input  logic        core_nonuni
);
    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        refeed_q, refeed_d;
    logic        trunc_q, trunc_d;
    logic        s_ready_q, s_ready_d;
    logic [31:0] m_data_q, m_data_d;
    logic [4:0]  m_flags_q, m_flags_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        fire_bin, fire_cout, fire_rst;
    logic        bin_idle, bin_done, cout_idle, cout_done, rst_idle, rst_done;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
    logic        last_q, last_d;
`else
    logic        unused_last;
    assign unused_last = s_last;
`endif

    utf8_strobe_gen #(.RST_VAL(STROBE_IDLE)) u_bin (
        .clk(clk), .rst(rst), .fire(fire_bin), .strobe_n(core_bin), .idle(bin_idle), .done(bin_done)
    );
    utf8_strobe_gen #(.RST_VAL(STROBE_IDLE)) u_cout (
        .clk(clk), .rst(rst), .fire(fire_cout), .strobe_n(core_cout), .idle(cout_idle), .done(cout_done)
    );
    // converter is held in reset while rst=1, so this strobe resets low
    utf8_strobe_gen #(.RST_VAL(~STROBE_IDLE)) u_rst (
        .clk(clk), .rst(rst), .fire(fire_rst), .strobe_n(core_rst_in), .idle(rst_idle), .done(rst_done)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        refeed_d  = refeed_q;
        trunc_d   = trunc_q;
        s_ready_d = 1'b0;
        m_data_d  = m_data_q;
        m_flags_d = m_flags_q;
        cnt_d     = cnt_q;
        fire_bin  = 1'b0;
        fire_cout = 1'b0;
        fire_rst  = 1'b0;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
        last_d    = last_q;
`endif
        case (state_q)
            CLR: begin
                fire_rst = rst_idle;
                trunc_d  = 1'b0;
                if (rst_done) state_d = FEED;
            end
            FEED: begin
                // a byte the converter asked to retry is replayed from hold_q, ignoring s_valid
                if (bin_idle && (refeed_q || s_valid)) begin
                    fire_bin = 1'b1;
                    refeed_d = 1'b0;
                    hold_d   = refeed_q ? hold_q : s_data;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
                    last_d   = refeed_q ? last_q : s_last;
`endif
                end
                // s_ready is registered here so it is high during CHECK, before FEED looks at s_valid again
                if (bin_done) begin
                    s_ready_d = ~core_retry;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                cnt_d = 2'd0;
                if (core_retry) begin
                    refeed_d = 1'b1;
                    state_d  = READ;
                end else if (core_ready) state_d = READ;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
                else if (last_q) begin
                    trunc_d = 1'b1;
                    state_d = READ;
                end
`endif
                else state_d = FEED;
            end
            READ: begin
                // next read pulse fires in the settle cycle of the previous one
                fire_cout = cout_idle || (cout_done && cnt_q != 2'(READ_COUNT - 1));
                if (cout_done) begin
                    m_data_d = {m_data_q[23:0], core_dout};
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'(READ_COUNT - 1)) begin
                        state_d                  = OUT;
                        m_flags_d[FLAG_TRUNC]    = trunc_q;
                        m_flags_d[FLAG_RETRY]    = core_retry;
                        m_flags_d[FLAG_INVALID]  = core_invalid;
                        m_flags_d[FLAG_OVERLONG] = core_overlong;
                        m_flags_d[FLAG_NONUNI]   = core_nonuni;
                    end
                end
            end
            OUT: if (m_ready) state_d = CLR;
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLR;
            hold_q    <= 8'd0;
            refeed_q  <= 1'b0;
            trunc_q   <= 1'b0;
            s_ready_q <= 1'b0;
            m_data_q  <= 32'd0;
            m_flags_q <= 5'd0;
            cnt_q     <= 2'd0;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            refeed_q  <= refeed_d;
            trunc_q   <= trunc_d;
            s_ready_q <= s_ready_d;
            m_data_q  <= m_data_d;
            m_flags_q <= m_flags_d;
            cnt_q     <= cnt_d;
`ifdef UTF8_SEQ_TRUNC_FLUSH_EN
            last_q    <= last_d;
`endif
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = state_q == OUT;
    assign m_data       = m_data_q;
    assign m_flags      = m_flags_q;
    assign core_din     = hold_q;
    assign core_rst_out = STROBE_IDLE;
endmodule
